// File: rtl/fir_mac_sequencer_if.sv
// Sample, coefficient-ROM and result signals of the FIR MAC sequencer.
// master = the sequencer, slave = front end / ROM / downstream side.
interface fir_mac_sequencer_if #(
    parameter int DW = 12,
    parameter int CW = 16,
    parameter int AW = 6
);
    logic                 f_s;
    logic signed [DW-1:0] din;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
    logic signed [DW-1:0] dout;
    logic                 dout_valid;
    logic                 busy;
    logic                 overrun;

    modport master (
        input  f_s, din, coef_data,
        output coef_addr, dout, dout_valid, busy, overrun
    );

    modport slave (
        output f_s, din, coef_data,
        input  coef_addr, dout, dout_valid, busy, overrun
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: one signed MAC shared across all taps.
// A rising edge of f_s captures a sample into a circular delay line, TAPS
// products are accumulated, then the sum is rounded, saturated and emitted
// with a one-cycle dout_valid strobe.
module fir_mac_sequencer #(
    parameter int TAPS   = 31,
    parameter int DW     = 12,
    parameter int CW     = 16,
    parameter int AW     = 6,
    parameter int ACCW   = 34,
    parameter int OSHIFT = 15
) (
    input  logic clk,
    input  logic rst,
    fir_mac_sequencer_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MAC   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] ROUND = 2'd3;

    localparam int PW = CW + DW;
    localparam logic [AW-1:0] TAPS_A = AW'(TAPS);
    localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);
    // Half-LSB rounding term; zero when no shift is applied.
    localparam int RSH = (OSHIFT > 0) ? OSHIFT - 1 : 0;
    localparam logic signed [ACCW-1:0] RND  = (OSHIFT > 0) ? (ACCW'(1) << RSH) : '0;
    localparam logic signed [ACCW-1:0] YMAX = ACCW'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACCW-1:0] YMIN = ~YMAX;

    logic [1:0] state;
    logic fs_meta, fs_sync, fs_prev, strobe;

    // Delay line sized to the address space so any pointer value is a legal
    // index; only entries 0..TAPS-1 are ever addressed.
    logic signed [DW-1:0] dline [2**AW];

    logic [AW-1:0]          wr_ptr, rd_ptr, k, tap_idx;
    logic signed [DW-1:0]   x_reg;
    logic signed [ACCW-1:0] acc, prod_ext, acc_rnd, y_shift;
    logic signed [PW-1:0]   prod;
    logic signed [DW-1:0]   y_sat;

    assign strobe        = fs_sync & ~fs_prev;
    assign bus.coef_addr = k;

    // Bring the slow sample clock into the clk domain and keep the last level
    // for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fs_meta <= 1'b0;
            fs_sync <= 1'b0;
            fs_prev <= 1'b0;
        end else begin
            fs_meta <= bus.f_s;
            fs_sync <= fs_meta;
            fs_prev <= fs_sync;
        end
    end

    // Circular read index x[n-k]: wraps below zero back to the top of the line.
    always_comb begin
        tap_idx = rd_ptr - k;
        if (rd_ptr < k) tap_idx = rd_ptr + TAPS_A - k;
    end

    // Product of the coefficient returned this cycle and the sample
    // registered alongside its address last cycle, sign-extended to ACCW.
    always_comb begin
        prod     = PW'(bus.coef_data) * PW'(x_reg);
        prod_ext = {{(ACCW - PW){prod[PW-1]}}, prod};
    end

    // Round-half-up, arithmetic shift, then clamp to the output range.
    always_comb begin
        acc_rnd = acc + RND;
        y_shift = acc_rnd >>> OSHIFT;
        y_sat   = y_shift[DW-1:0];
        if (y_shift > YMAX)      y_sat = YMAX[DW-1:0];
        else if (y_shift < YMIN) y_sat = YMIN[DW-1:0];
    end

    // Sample capture into the delay line; only accepted in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**AW; i++) dline[i] <= '0;
        end else if (state == IDLE && strobe) begin
            dline[wr_ptr] <= bus.din;
        end
    end

    // Sequencer: capture, TAPS MAC cycles, drain of the last product, round.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            k              <= '0;
            x_reg          <= '0;
            acc            <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.dout_valid <= 1'b0;
            // busy covers the dout_valid cycle, then drops unless a new
            // capture re-arms it below.
            if (bus.dout_valid) bus.busy <= 1'b0;
            // Edges arriving mid-computation are dropped and flagged.
            if (strobe && state != IDLE) bus.overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (strobe) begin
                        rd_ptr   <= wr_ptr;
                        wr_ptr   <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                        k        <= '0;
                        acc      <= '0;
                        bus.busy <= 1'b1;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    x_reg <= dline[tap_idx];
                    // ROM data lags the address by one cycle, so nothing
                    // valid is available to add on the first tap.
                    if (k != '0) acc <= acc + prod_ext;
                    if (k == LAST) begin
                        k     <= '0;
                        state <= DRAIN;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    acc   <= acc + prod_ext;
                    state <= ROUND;
                end
                ROUND: begin
                    bus.dout       <= y_sat;
                    bus.dout_valid <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer (default parameters). A
// behavioural model keeps the accepted sample history in a queue and forms
// the filter output directly as a rounded, saturated convolution.
module tb_fir_mac_sequencer;
    localparam int TAPS = 31;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    logic signed [15:0] coef_rom [64];
    int hist[$];

    fir_mac_sequencer_if #(.DW(12), .CW(16), .AW(6)) bus ();

    fir_mac_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous coefficient ROM: data valid one clk after the address.
    always @(posedge clk) bus.coef_data <= coef_rom[bus.coef_addr];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int model_y();
        longint s = 0;
        for (int kk = 0; kk < TAPS; kk++) begin
            int idx = hist.size() - 1 - kk;
            if (idx >= 0) s += longint'(coef_rom[kk]) * longint'(hist[idx]);
        end
        s = (s + 64'sd16384) >>> 15;
        if (s > 2047)  return 2047;
        if (s < -2048) return -2048;
        return int'(s);
    endfunction

    task automatic set_coef_const(input int c);
        for (int i = 0; i < 64; i++) coef_rom[i] = 16'(c);
    endtask

    task automatic set_coef_random();
        for (int i = 0; i < 64; i++) coef_rom[i] = 16'(int'($urandom_range(0, 8191)) - 4096);
    endtask

    task automatic set_coef_ramp();
        for (int i = 0; i < 64; i++) coef_rom[i] = 16'((i + 1) * 1024);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.f_s = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        hist.delete();
        repeat (3) @(negedge clk);
    endtask

    // One sample: raise f_s, measure clks from the first busy cycle to
    // dout_valid, then count any extra valid pulses in a short tail.
    task automatic drive_sample(input logic signed [11:0] d, output logic signed [11:0] got,
                                output int lat, output int nv);
        int t;
        got = '0; lat = -1; nv = 0;
        @(negedge clk);
        bus.din = d;
        bus.f_s = 1'b1;
        t = 0;
        while (bus.busy !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (bus.busy === 1'b1) begin
            for (int c = 1; c <= 100; c++) begin
                @(negedge clk);
                if (bus.dout_valid === 1'b1) begin
                    got = bus.dout; lat = c; nv = 1;
                    break;
                end
            end
        end
        bus.f_s = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.dout_valid === 1'b1) nv++;
        end
    endtask

    task automatic test_reset();
        logic signed [11:0] got;
        int lat, nv;
        set_coef_random();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.din = 12'($urandom);
            bus.f_s = 1'($urandom);
        end
        tests++; if (bus.dout !== 12'sd0) begin fails++; $display("FAIL reset_dout got=%0d want=0", bus.dout); end
        tests++; if (bus.dout_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", bus.dout_valid); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got=%b want=0", bus.overrun); end
        tests++; if (bus.coef_addr !== 6'd0) begin fails++; $display("FAIL reset_coef_addr got=%0d want=0", bus.coef_addr); end
        @(negedge clk);
        bus.f_s = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        hist.delete();
        repeat (3) @(negedge clk);
        drive_sample(12'sd0, got, lat, nv);
        hist.push_back(0);
        tests++; if (got !== 12'sd0 || lat != 33 || nv != 1)
            begin fails++; $display("FAIL reset_first_sample dout=%0d lat=%0d valids=%0d want 0/33/1", got, lat, nv); end
    endtask

    // Impulse of height 32 against coef[k]=(k+1)*1024 yields exactly k+1.
    task automatic run_impulse(input string tag);
        logic signed [11:0] got;
        int lat, nv, e;
        set_coef_ramp();
        for (int i = 0; i < 33; i++) begin
            drive_sample((i == 0) ? 12'sd32 : 12'sd0, got, lat, nv);
            e = (i < 31) ? i + 1 : 0;
            tests++; if (got !== 12'(e) || lat != 33 || nv != 1)
                begin fails++; $display("FAIL %s[%0d] dout=%0d lat=%0d valids=%0d want %0d/33/1", tag, i, got, lat, nv, e); end
        end
    endtask

    task automatic test_impulse();
        apply_reset();
        run_impulse("impulse");
    endtask

    task automatic test_dc_gain();
        logic signed [11:0] got;
        int lat, nv, e;
        apply_reset();
        set_coef_const(1024);
        for (int i = 0; i < 35; i++) begin
            drive_sample(12'sd1000, got, lat, nv);
            hist.push_back(1000);
            e = model_y();
            tests++; if (got !== 12'(e) || nv != 1)
                begin fails++; $display("FAIL dc[%0d] dout=%0d valids=%0d want %0d/1", i, got, nv, e); end
            if (i >= 30) begin
                tests++; if (got !== 12'sd969) begin fails++; $display("FAIL dc_steady[%0d] dout=%0d want 969", i, got); end
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [11:0] got;
        int lat, nv, e;
        apply_reset();
        set_coef_const(32767);
        for (int i = 0; i < 33; i++) begin
            drive_sample(12'sd2047, got, lat, nv);
            hist.push_back(2047);
            tests++; if (got !== 12'sd2047) begin fails++; $display("FAIL sat_pos[%0d] dout=%0d want 2047", i, got); end
        end
        for (int i = 0; i < 33; i++) begin
            drive_sample(-12'sd2048, got, lat, nv);
            hist.push_back(-2048);
            e = model_y();
            tests++; if (got !== 12'(e)) begin fails++; $display("FAIL sat_neg[%0d] dout=%0d want %0d", i, got, e); end
        end
        tests++; if (got !== -12'sd2048) begin fails++; $display("FAIL sat_floor dout=%0d want -2048", got); end
    endtask

    // Two rising edges j clks apart (counted from the first busy cycle).
    task automatic edge_pair(input int j, input bit accept, input string tag);
        logic signed [11:0] a, b;
        int vcyc[$];
        logic signed [11:0] vdat[$];
        int t, e1, e2, first;
        apply_reset();
        a = 12'($urandom);
        b = 12'($urandom);
        @(negedge clk);
        bus.din = a;
        bus.f_s = 1'b1;
        t = 0;
        while (bus.busy !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        hist.push_back(int'(a));
        e1 = model_y();
        for (int n = 1; n <= 90; n++) begin
            @(negedge clk);
            if (n == 2) bus.f_s = 1'b0;
            if (n == j) begin bus.din = b; bus.f_s = 1'b1; end
            if (n == j + 6) bus.f_s = 1'b0;
            if (bus.dout_valid === 1'b1) begin vcyc.push_back(n); vdat.push_back(bus.dout); end
        end
        first = (vcyc.size() > 0) ? vcyc[0] : -1;
        tests++; if (first != 33 || vdat.size() == 0 || vdat[0] !== 12'(e1))
            begin fails++; $display("FAIL %s_first cyc=%0d want 33, want dout %0d", tag, first, e1); end
        tests++; if (bus.overrun !== !accept)
            begin fails++; $display("FAIL %s_overrun got=%b want=%b", tag, bus.overrun, !accept); end
        if (accept) begin
            hist.push_back(int'(b));
            e2 = model_y();
            tests++; if (vdat.size() != 2 || vdat[vdat.size()-1] !== 12'(e2))
                begin fails++; $display("FAIL %s_second valids=%0d want 2, want dout %0d", tag, vdat.size(), e2); end
        end else begin
            tests++; if (vcyc.size() != 1)
                begin fails++; $display("FAIL %s_dropped valids=%0d want 1", tag, vcyc.size()); end
        end
    endtask

    task automatic test_overrun();
        logic signed [11:0] got, c;
        int lat, nv, e;
        set_coef_random();
        edge_pair(10, 1'b0, "overrun");
        c = 12'($urandom);
        drive_sample(c, got, lat, nv);
        hist.push_back(int'(c));
        e = model_y();
        tests++; if (got !== 12'(e) || nv != 1)
            begin fails++; $display("FAIL overrun_history dout=%0d valids=%0d want %0d/1", got, nv, e); end
        tests++; if (bus.overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky got=%b want=1", bus.overrun); end
    endtask

    task automatic test_round_boundary();
        set_coef_random();
        edge_pair(30, 1'b0, "edge_in_round");
        edge_pair(31, 1'b1, "edge_after_round");
    endtask

    task automatic test_reset_mid_mac();
        int t, nv;
        apply_reset();
        set_coef_ramp();
        @(negedge clk);
        bus.din = 12'($urandom);
        bus.f_s = 1'b1;
        t = 0;
        while (bus.coef_addr !== 6'd12 && t < 60) begin
            @(negedge clk);
            t++;
        end
        tests++; if (bus.coef_addr !== 6'd12) begin fails++; $display("FAIL midmac_reach coef_addr=%0d want 12", bus.coef_addr); end
        rst = 1'b0;
        #1;
        tests++; if (bus.busy !== 1'b0 || bus.dout_valid !== 1'b0 || bus.coef_addr !== 6'd0)
            begin fails++; $display("FAIL midmac_abort busy=%b valid=%b addr=%0d want 0/0/0", bus.busy, bus.dout_valid, bus.coef_addr); end
        bus.f_s = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        hist.delete();
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.dout_valid === 1'b1) nv++;
        end
        tests++; if (nv != 0) begin fails++; $display("FAIL midmac_no_valid valids=%0d want 0", nv); end
        run_impulse("midmac_impulse");
    endtask

    task automatic test_random();
        logic signed [11:0] got, d;
        int lat, nv, e;
        apply_reset();
        set_coef_random();
        for (int i = 0; i < 40; i++) begin
            d = 12'($urandom);
            drive_sample(d, got, lat, nv);
            hist.push_back(int'(d));
            e = model_y();
            tests++; if (got !== 12'(e) || lat != 33 || nv != 1)
                begin fails++; $display("FAIL random[%0d] dout=%0d lat=%0d valids=%0d want %0d/33/1", i, got, lat, nv, e); end
        end
    endtask

    initial begin
        bus.f_s = 1'b0;
        bus.din = '0;
        test_reset();
        test_impulse();
        test_dc_gain();
        test_saturation();
        test_overrun();
        test_round_boundary();
        test_reset_mid_mac();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Time-multiplexed controller for the FIR filter datapath. One signed multiplier-accumulator is shared across all taps.
- Each rising edge of the slow sample clock f_s captures one input sample into a circular delay line.
- The block then sequences TAPS coefficient/sample pairs through the MAC, rounds and saturates the sum, and presents one filtered output with a one-cycle valid strobe.
- It sits between the function-generator/mux front end and downstream consumers. Filter type (LPF/HPF/BPF) is set only by the external coefficient ROM contents.

Parameters:
- TAPS, 31, number of filter taps (2..64)
- DW, 12, signed sample width, input and output
- CW, 16, signed coefficient width (Q1.15)
- AW, 6, coefficient/sample address width; must satisfy 2^AW >= TAPS
- ACCW, 34, signed accumulator width; must be >= DW+CW+clog2(TAPS)
- OSHIFT, 15, arithmetic right shift applied to the accumulator before output

Ports:
- clk, in, 1, system clock
- rst, in, 1, asynchronous active-low reset
- f_s, in, 1, sample clock, asynchronous to clk, much slower than clk
- din, in, DW, signed input sample
- coef_addr, out, AW, coefficient ROM address (tap index k)
- coef_data, in, CW, signed coefficient; synchronous ROM, valid 1 clk after coef_addr
- dout, out, DW, signed filtered output
- dout_valid, out, 1, one-clk pulse when dout updates
- busy, out, 1, high from sample capture until the dout_valid cycle inclusive
- overrun, out, 1, sticky: a sample edge arrived while busy

Behaviour:
- Reset (rst=0, async): dout=0, dout_valid=0, busy=0, overrun=0, coef_addr=0. Accumulator, pointers and all TAPS delay-line entries are cleared to 0. FSM goes to IDLE.
- Reset mid-operation aborts immediately. No dout_valid is issued for the aborted sample.
- f_s synchronisation:
  - 2-FF synchroniser, then a rising-edge detector.
  - The internal strobe is high for exactly one clk.
  - A falling edge of f_s has no effect.
- FSM states: IDLE, MAC, DRAIN, ROUND.
- IDLE with strobe (capture edge):
  - buf[wr_ptr] <= din.
  - rd_ptr <= wr_ptr.
  - wr_ptr <= (wr_ptr+1) mod TAPS.
  - k <= 0, acc <= 0, busy <= 1.
  - Go to MAC.
- MAC, TAPS cycles:
  - Cycle k: coef_addr=k; sample x[n-k]=buf[(rd_ptr-k) mod TAPS] is registered alongside.
  - The product coef_data*x from the previous cycle is added to acc (first cycle adds nothing).
  - After k=TAPS-1, go to DRAIN.
- DRAIN: add the final product; go to ROUND.
- ROUND:
  - y = (acc + 2^(OSHIFT-1)) >>> OSHIFT; no rounding term when OSHIFT=0.
  - Saturate y to [-2^(DW-1), 2^(DW-1)-1] and register it into dout.
  - dout_valid=1 for this one cycle. busy drops on the next clk. Go to IDLE.
- Latency: dout_valid rises TAPS+2 clk edges after the capture edge (33 for defaults).
- dout holds its value between updates.
- Pointer wrap: rd_ptr-k below 0 wraps to +TAPS. wr_ptr wraps TAPS-1 -> 0.
- Arithmetic: signed multiply CW x DW into ACCW, with no internal overflow under legal parameters.
- Boundary cases:
  - Strobe while not IDLE: the sample is dropped (buffer and pointers unchanged), overrun <= 1 (sticky until reset), and the current computation continues undisturbed.
  - Strobe in the same cycle as the ROUND cycle: counts as overrun.
  - Strobe on the cycle after ROUND: accepted normally.
- Until TAPS samples have been taken, outputs are partial sums over the zeroed history.

Test Plan:
1. Reset: hold rst=0 with random din/f_s -> dout=0, dout_valid=0, busy=0, overrun=0, coef_addr=0. Release, pulse f_s once with din=0 -> dout=0 after exactly 33 clks from capture.
2. Impulse (OSHIFT=0, ROM coef[k]=k+1): din=1 on first sample, then 0 for 32 samples -> dout sequence 1,2,3,...,31, then 0,0. One dout_valid per sample.
3. DC gain (defaults, all coef=1024): din=1000 constant -> outputs ramp and reach a steady 969 from the 31st sample onward (31*1000*1024/32768 = 968.75, rounded).
4. Saturation (all coef=32767): din=2047 constant -> dout clamps to 2047. Switch to din=-2048 -> dout clamps to -2048 once the history is full. No wrap to the opposite sign at any point.
5. Overrun: two f_s rising edges 10 clks apart -> overrun=1 and stays 1. Only one dout_valid. Next output equals the single-sample result, i.e. the second sample never appears in the history.
6. Reset mid-MAC: assert rst at MAC cycle k=12 -> no dout_valid, busy=0. After release, the impulse test of scenario 2 reproduces exactly 1,2,3,... with no residue from the aborted sample.
